// File: rtl/uart_tx_if.sv
// uart_tx_if: push side and status/serial signals of the UART transmitter
interface uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       uart_out;
  modport master (output wr_en, wr_data, input full, empty, busy, overflow, uart_out);
  modport slave (input wr_en, wr_data, output full, empty, busy, overflow, uart_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular write FIFO
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int FIFO_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int TW = BIT_TICKS > 1 ? $clog2(BIT_TICKS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] tick, tick_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          last, push, pop, uart_nxt;
  assign bus.full  = count == (AW+1)'(FIFO_DEPTH);
  assign bus.empty = count == '0;
  assign push      = bus.wr_en & ~bus.full;
  assign last      = tick == TW'(BIT_TICKS - 1);
  assign pop       = ~bus.empty & (state == IDLE | (state == STOP & last));
  // FIFO storage needs no reset; the count alone defines validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.wr_data;
  // pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      count        <= count + (AW+1)'(push) - (AW+1)'(pop);
      bus.overflow <= bus.overflow | (bus.wr_en & bus.full);
    end
  // FSM state, bit timing and the registered serial line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      tick         <= '0;
      bit_idx      <= '0;
      sh           <= '0;
      bus.uart_out <= 1'b1;
    end else begin
      state        <= state_nxt;
      tick         <= tick_nxt;
      bit_idx      <= bit_nxt;
      sh           <= sh_nxt;
      bus.uart_out <= uart_nxt;
    end
  // next state: bits end on the last tick, STOP chains straight into the next START
  always_comb
    state_nxt = state == IDLE ? (bus.empty ? IDLE : START) :
                !last         ? state :
                state == START ? DATA :
                state == DATA  ? (bit_idx == 3'd7 ? STOP : DATA) :
                (bus.empty ? IDLE : START);
  // datapath updates; the line level is precomputed from the state being entered
  always_comb begin
    tick_nxt = (state == IDLE | last) ? '0 : tick + TW'(1);
    bit_nxt  = (state == DATA & last) ? bit_idx + 3'd1 : bit_idx;
    sh_nxt   = pop ? mem[rd_ptr] : (state == DATA & last) ? {1'b0, sh[7:1]} : sh;
    uart_nxt = state_nxt == DATA ? sh_nxt[0] : state_nxt != START;
    bus.busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (BIT_TICKS=10)
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  uart_tx_if bus();
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_one(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step(1);
    bus.wr_en   = 1'b0;
  endtask
  task automatic frame(input string tag, input logic [7:0] b, input int skip);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = skip; i < 100; i++) begin
      chk($sformatf("%s_line%0d", tag, i), 32'(bus.uart_out), 32'(f[i/10]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
      step(1);
    end
  endtask
  task automatic rx(input int budget, output logic [7:0] b);
    int w;
    w = 0;
    b = '0;
    while (bus.uart_out !== 1'b0 && w < budget) begin
      step(1);
      w++;
    end
    chk("rx_start_seen", 32'(bus.uart_out), 32'd0);
    step(5);
    chk("rx_start_mid", 32'(bus.uart_out), 32'd0);
    for (int j = 0; j < 8; j++) begin
      step(10);
      b[j] = bus.uart_out;
    end
    step(10);
    chk("rx_stop_mid", 32'(bus.uart_out), 32'd1);
    step(5);
  endtask
  initial begin
    logic [7:0] got;
    logic [7:0] exp;
    logic       saw_low;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_uart", 32'(bus.uart_out), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    push_one(8'h61);
    chk("s_uart_push", 32'(bus.uart_out), 32'd1);
    chk("s_empty_push", 32'(bus.empty), 32'd0);
    chk("s_busy_push", 32'(bus.busy), 32'd0);
    step(1);
    chk("s_latency", 32'(bus.uart_out), 32'd0);
    frame("s61", 8'h61, 0);
    chk("s_busy_end", 32'(bus.busy), 32'd0);
    chk("s_uart_end", 32'(bus.uart_out), 32'd1);
    chk("s_empty_end", 32'(bus.empty), 32'd1);
    step(5);
    chk("s_idle_line", 32'(bus.uart_out), 32'd1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h7A;
    step(1);
    bus.wr_data = 8'h78;
    step(1);
    bus.wr_en   = 1'b0;
    chk("b_empty_q", 32'(bus.empty), 32'd0);
    frame("b7a", 8'h7A, 0);
    chk("b_empty_pop2", 32'(bus.empty), 32'd1);
    frame("b78", 8'h78, 0);
    chk("b_busy_end", 32'(bus.busy), 32'd0);
    chk("b_uart_end", 32'(bus.uart_out), 32'd1);
    bus.wr_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.wr_data = 8'(k);
      step(1);
      if (k == 5) begin
        chk("o_full", 32'(bus.full), 32'd1);
        chk("o_ovf_before", 32'(bus.overflow), 32'd0);
      end
    end
    bus.wr_en = 1'b0;
    chk("o_ovf_set", 32'(bus.overflow), 32'd1);
    chk("o_full_hold", 32'(bus.full), 32'd1);
    frame("o01", 8'h01, 4);
    chk("o_full_clear", 32'(bus.full), 32'd0);
    for (int k = 2; k <= 5; k++) frame($sformatf("o%02x", k), 8'(k), 0);
    chk("o_busy_end", 32'(bus.busy), 32'd0);
    chk("o_empty_end", 32'(bus.empty), 32'd1);
    saw_low = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.uart_out !== 1'b1) saw_low = 1'b1;
      step(1);
    end
    chk("o_no_sixth", 32'(saw_low), 32'd0);
    chk("o_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h63;
    step(1);
    bus.wr_data = 8'h11;
    step(1);
    bus.wr_data = 8'h22;
    step(1);
    bus.wr_en   = 1'b0;
    step(43);
    chk("r_bit3", 32'(bus.uart_out), 32'd0);
    chk("r_busy", 32'(bus.busy), 32'd1);
    chk("r_queued", 32'(bus.empty), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("r_uart", 32'(bus.uart_out), 32'd1);
    chk("r_empty", 32'(bus.empty), 32'd1);
    chk("r_busy0", 32'(bus.busy), 32'd0);
    chk("r_ovf_clr", 32'(bus.overflow), 32'd0);
    chk("r_full", 32'(bus.full), 32'd0);
    #1 rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (bus.uart_out !== 1'b1) saw_low = 1'b1;
    end
    chk("r_quiet", 32'(saw_low), 32'd0);
    chk("r_empty_after", 32'(bus.empty), 32'd1);
    chk("r_busy_after", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 9; k++) begin
      exp = 8'hA5 ^ 8'(k * 37);
      push_one(exp);
      rx(5, got);
      chk($sformatf("w_byte%0d", k), 32'(got), 32'(exp));
      chk($sformatf("w_idle%0d", k), 32'(bus.busy), 32'd0);
    end
    chk("w_empty_end", 32'(bus.empty), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-serial UART transmitter with a small write FIFO.
- Drives the asynchronous serial line that feeds the team's UART key receivers. It sits on the host link, or on loopback in the FPGA test harness.
- The processor or test logic pushes bytes. The block frames each byte as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit) and shifts it out at the agreed baud rate.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9_600, line baud rate; must match the receivers.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2, at least 2.
- BIT_TICKS, CLK_FREQ/BAUD_RATE (derived, 10416 at defaults), clock cycles per serial bit.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request; sampled on the rising edge of clk.
- wr_data  in  8  byte to push; valid when wr_en=1.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  a frame is being shifted (FSM not in IDLE).
- overflow  out  1  sticky flag: a push was attempted while full.
- uart_out  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately, independent of clk.
  - State after reset: uart_out=1, busy=0, empty=1, full=0, overflow=0, FIFO count=0, FSM in IDLE, bit and tick counters at 0.
  - Reset asserted mid-frame aborts the frame; the line returns high at once.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
  - full and empty are decoded from the registered count.
- Push:
  - A push is accepted when wr_en=1 and full=0 at the edge. The byte is written at the write pointer and the pointer increments.
  - wr_en=1 with full=1 drops the byte and sets overflow=1 on that edge.
  - A push is rejected when full, even if a pop occurs on the same edge.
- Pop:
  - Done only by the FSM, only when empty=0.
- Simultaneous push and pop on one edge: count is unchanged and both pointers advance.
- Output register: uart_out is driven from a flop; no combinational path from any input.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - uart_out=1.
    - If empty=0 at the edge: pop the head into an 8-bit shift register, clear the tick counter, go to START.
    - With empty=0, uart_out falls on the same edge.
    - Latency: a byte pushed into an empty FIFO while IDLE gets its start bit exactly 1 clock after the push edge.
  - START:
    - uart_out=0 for BIT_TICKS cycles.
    - Then go to DATA with bit index 0.
  - DATA:
    - uart_out = shift register bit 0.
    - Every BIT_TICKS cycles: shift right, increment the 3-bit bit index.
    - After bit index 7 completes, go to STOP.
  - STOP:
    - uart_out=1 for BIT_TICKS cycles.
    - At the end, if empty=0: pop and go directly to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- Frame timing: every frame is exactly 10*BIT_TICKS cycles from the start-bit falling edge to the end of the stop bit.
- Tick counter:
  - Counts 0..BIT_TICKS-1 and wraps to 0 on the last tick of each bit.
  - Must be wide enough for BIT_TICKS-1; 14 bits at defaults.
- busy: 1 in START, DATA and STOP; 0 in IDLE.
- A push while busy is permitted. It changes neither the byte in flight nor the timing.

Test Plan:
- Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BIT_TICKS=10.
- Reset values: assert rst mid-clock with no clk edge -> uart_out=1, empty=1, busy=0, overflow=0 immediately.
- Single byte: push 0x61 while IDLE -> 1 clock later uart_out carries 0, 1,0,0,0,0,1,1,0, 1, each level held exactly 10 clocks. busy=1 for 100 clocks, then IDLE, line high.
- Back-to-back: push 0x7A, 0x78 on consecutive cycles -> two 100-clock frames with no idle clock between them. Second frame data bits are 0,0,0,1,1,1,1,0. empty=1 once the second byte is popped.
- Overflow and full:
  - Push 6 bytes 0x01..0x06 on 6 consecutive cycles from IDLE.
  - 0x01 is popped 1 clock after its push, so 0x02..0x05 fill the FIFO and full=1.
  - 0x06 is dropped and overflow=1, and stays 1 until rst.
  - Exactly 5 frames are sent: 0x01..0x05.
- Reset mid-frame: assert rst during DATA bit 3 of 0x63 with 2 bytes still queued -> uart_out=1 at once, FIFO empty. After release the line stays high with no further frames.
- Pointer wrap: push and transmit 9 bytes one at a time, each after the previous frame ends -> pointers wrap twice and all 9 bytes are received in order by a UART_receiver_switch-style bench monitor.
